uart_txrx_core: RTL and testbench
=================================

UART_TXRX_CORE -- requirements
Module: uart_txrx_core

Interface
REQ-001 SHALL have parameter C_F_CK, default 135_000_000, meaning clock frequency in Hz.
REQ-002 SHALL have parameter C_BAUD, default 31_250, meaning bit rate in bps.
REQ-003 SHALL have port CK_i, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port RST_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port BYTEs_i, input, 8 bits: byte to transmit.
REQ-006 SHALL have port REQ_i, input, 1 bit: level transmit request.
REQ-007 SHALL have port STB_o, output, 1 bit: TX ready (1 = idle, accepts REQ_i).
REQ-008 SHALL have port TXD_o, output, 1 bit: serial out, idle high.
REQ-009 SHALL have port RXD_i, input, 1 bit: asynchronous serial in, idle high.
REQ-010 SHALL have port BYTEs_o, output, 8 bits: last received byte.
REQ-011 SHALL have port DONE_o, output, 1 bit: one-cycle pulse when a byte is received.
REQ-012 SHALL have ports HEXs_o (4 bits), CRLF_DET_o, W_DET_o and R_DET_o (1 bit each), outputs: decode flags of the received byte.

Function
REQ-013 SHALL use bit period DIV = (C_F_CK + C_BAUD/2) / C_BAUD clocks; DIV >= 4 is required.
REQ-014 SHALL frame 8N1: start 0, data bits LSB first, stop 1; each bit DIV clocks.
REQ-015 SHALL latch BYTEs_i at any edge with STB_o=1 and REQ_i=1; STB_o=0 from the next cycle; the start bit begins that same cycle.
REQ-016 SHALL return STB_o to 1 exactly 10*DIV cycles after it fell (end of the stop bit); if REQ_i is still 1, the next byte SHALL start immediately (back-to-back).
REQ-017 SHALL keep TXD_o=1 and STB_o=1 while idle; REQ_i changes during a frame SHALL be ignored.
REQ-018 SHALL pass RXD_i through a 2-flop synchronizer before all RX logic.
REQ-019 SHALL detect a start on a synchronized 1->0 edge while RX is idle, and sample at the start-bit centre (DIV/2 clocks after the edge); a sample of 1 = false start, return to idle, no DONE_o.
REQ-020 SHALL sample data bits and the stop bit at successive centres, DIV apart.
REQ-021 SHALL behave as follows on stop = 1: update BYTEs_o, decode flags and DONE_o=1 in the same cycle, then return to idle at once.
REQ-022 SHALL behave as follows on stop = 0 (framing error): no DONE_o and no output update; wait until the line is 1 before re-arming.
REQ-023 SHALL hold BYTEs_o and the flags between DONE_o pulses.
REQ-024 SHALL decode as follows: HEXs_o = value of '0'-'9', 'A'-'F' or 'a'-'f', else 0; CRLF_DET_o = byte is 0x0D or 0x0A; W_DET_o = 'W' or 'w'; R_DET_o = 'R' or 'r'.
REQ-025 SHALL operate TX and RX fully independently; simultaneous activity is allowed.

Reset
REQ-026 SHALL apply these reset values: TXD_o=1, STB_o=1, DONE_o=0, BYTEs_o=0, HEXs_o=0, all DET flags 0, synchronizer flops=1, both FSMs idle.
REQ-027 SHALL abort any frame in progress when reset is asserted; TXD_o SHALL be 1 in the next cycle.

Configuration
REQ-028 SHALL, with macro UART_RX_CMD_DECODE_EN defined, implement REQ-024.
REQ-029 SHALL, without UART_RX_CMD_DECODE_EN, tie HEXs_o, CRLF_DET_o, W_DET_o and R_DET_o to 0 and synthesize no decode logic.

Structure
REQ-030 SHALL use a shared package uart_pkg holding the DIV calculation function, the 8N1 bit-count constant (10) and the ASCII constants (0x0D, 0x0A, 'W', 'w', 'R', 'r', '0', 'A', 'a').
REQ-031 SHALL use one sub-module, uart_bit_timer (a DIV counter with a half-period preload), instantiated once for TX and once for RX.

Verification
REQ-032 SHALL pass loopback with C_F_CK=1000 and C_BAUD=100 (DIV=10): a TXD_o->RXD_i driver raises REQ_i on STB_o rise and drops it and increments the byte on STB_o fall, bytes 0x00..0xFF; each DONE_o SHALL show BYTEs_o equal to the byte sent, in order.
REQ-033 SHALL pass TX timing: REQ_i with 0x55 -> TXD_o = 0,1,0,1,0,1,0,1,0,1, each held 10 clocks; STB_o low 100 clocks.
REQ-034 SHALL pass decode: receive 'a', 'W', 'r' and 0x0D -> HEXs_o=0xA; W_DET_o=1; R_DET_o=1; CRLF_DET_o=1 and HEXs_o=0.
REQ-035 SHALL pass false start and framing: a 3-clock low glitch on RXD_i -> no DONE_o; a frame with stop=0 -> no DONE_o, and the next valid byte is received correctly.
REQ-036 SHALL pass reset: RST_i asserted mid-TX-frame -> TXD_o=1 and STB_o=1 the next cycle; RST_i mid-RX-frame -> no DONE_o.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: bit-period calculation, 8N1 frame length, ASCII codes,
// FSM state types and the received-byte command decoder.
package uart_pkg;

  localparam int LP_FRAME_BITS = 10;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_W_UP = 8'h57;
  localparam logic [7:0] ASCII_W_LO = 8'h77;
  localparam logic [7:0] ASCII_R_UP = 8'h52;
  localparam logic [7:0] ASCII_R_LO = 8'h72;
  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_A_UP = 8'h41;
  localparam logic [7:0] ASCII_A_LO = 8'h61;

  typedef enum logic {
    TX_IDLE,
    TX_BUSY
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  typedef struct packed {
    logic [3:0] hex;
    logic       crlf;
    logic       w;
    logic       r;
  } rx_flags_t;

  // Bit period in clocks, rounded to nearest.
  function automatic int calc_div(input int f_ck, input int baud);
    return (f_ck + baud / 2) / baud;
  endfunction

  function automatic rx_flags_t decode_byte(input logic [7:0] b);
    rx_flags_t f;
    f = '0;
    if (b >= ASCII_0 && b <= ASCII_0 + 8'd9)
      f.hex = 4'(b - ASCII_0);
    else if (b >= ASCII_A_UP && b <= ASCII_A_UP + 8'd5)
      f.hex = 4'(b - ASCII_A_UP + 8'd10);
    else if (b >= ASCII_A_LO && b <= ASCII_A_LO + 8'd5)
      f.hex = 4'(b - ASCII_A_LO + 8'd10);
    f.crlf = (b == ASCII_CR)   || (b == ASCII_LF);
    f.w    = (b == ASCII_W_UP) || (b == ASCII_W_LO);
    f.r    = (b == ASCII_R_UP) || (b == ASCII_R_LO);
    return f;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: restarts with a full or half period, then ticks every C_DIV
// clocks until stopped. o_tick is high in the last clock of each period.
module uart_bit_timer #(
  parameter int C_DIV = 10
) (
  input  logic i_ck,
  input  logic i_rst,
  input  logic i_start,
  input  logic i_half,
  input  logic i_stop,
  output logic o_tick
);

  localparam int              LP_W    = $clog2(C_DIV);
  localparam logic [LP_W-1:0] LP_FULL = LP_W'(C_DIV - 1);
  localparam logic [LP_W-1:0] LP_HALF = LP_W'(C_DIV / 2 - 1);

  logic [LP_W-1:0] r_cnt;
  logic            r_run;

  // NOTE: sequential state is only ever written with non-blocking assignments so
  // every flop samples the pre-edge values of its neighbours.
  always_ff @(posedge i_ck) begin
    if (i_rst) begin
      r_run <= 1'b0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_run <= 1'b1;
      r_cnt <= i_half ? LP_HALF : LP_FULL;
    end else if (i_stop) begin
      r_run <= 1'b0;
    end else if (r_run) begin
      r_cnt <= (r_cnt == '0) ? LP_FULL : r_cnt - LP_W'(1);
    end
  end

  assign o_tick = r_run && (r_cnt == '0);

endmodule

// File: rtl/uart_txrx_core.sv
// Independent 8N1 UART transmitter and receiver sharing one clock.
// Optional feature macro UART_RX_CMD_DECODE_EN enables the received-byte decode flags.
module uart_txrx_core
  import uart_pkg::*;
#(
  parameter int C_F_CK = 135_000_000,
  parameter int C_BAUD = 31_250
) (
  input  logic       CK_i,
  input  logic       RST_i,
  input  logic [7:0] BYTEs_i,
  input  logic       REQ_i,
  output logic       STB_o,
  output logic       TXD_o,
  input  logic       RXD_i,
  output logic [7:0] BYTEs_o,
  output logic       DONE_o,
  output logic [3:0] HEXs_o,
  output logic       CRLF_DET_o,
  output logic       W_DET_o,
  output logic       R_DET_o
);

  localparam int LP_DIV = calc_div(C_F_CK, C_BAUD);

  // ---------------- transmitter ----------------
  tx_state_t  r_tx_state, w_tx_state_nxt;
  logic [8:0] r_tx_shift, w_tx_shift_nxt;
  logic [3:0] r_tx_cnt,   w_tx_cnt_nxt;
  logic       r_txd,      w_txd_nxt;
  logic       r_stb,      w_stb_nxt;
  logic       w_tx_tick, w_tx_tmr_start, w_tx_tmr_stop;

  uart_bit_timer #(.C_DIV(LP_DIV)) u_tx_timer (
    .i_ck   (CK_i),
    .i_rst  (RST_i),
    .i_start(w_tx_tmr_start),
    .i_half (1'b0),
    .i_stop (w_tx_tmr_stop),
    .o_tick (w_tx_tick)
  );

  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      r_tx_state <= TX_IDLE;
      r_tx_shift <= '1;
      r_tx_cnt   <= '0;
      r_txd      <= 1'b1;
      r_stb      <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_txd      <= w_txd_nxt;
      r_stb      <= w_stb_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_shift_nxt = r_tx_shift;
    w_tx_cnt_nxt   = r_tx_cnt;
    w_txd_nxt      = r_txd;
    w_stb_nxt      = r_stb;
    w_tx_tmr_start = 1'b0;
    w_tx_tmr_stop  = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        if (REQ_i) begin
          // Stop bit rides in the shift register above the data so it falls out last.
          w_tx_shift_nxt = {1'b1, BYTEs_i};
          w_tx_cnt_nxt   = '0;
          w_txd_nxt      = 1'b0;
          w_stb_nxt      = 1'b0;
          w_tx_tmr_start = 1'b1;
          w_tx_state_nxt = TX_BUSY;
        end
      end
      TX_BUSY: begin
        if (w_tx_tick) begin
          if (r_tx_cnt == 4'(LP_FRAME_BITS - 1)) begin
            w_txd_nxt      = 1'b1;
            w_stb_nxt      = 1'b1;
            w_tx_tmr_stop  = 1'b1;
            w_tx_state_nxt = TX_IDLE;
          end else begin
            w_txd_nxt      = r_tx_shift[0];
            w_tx_shift_nxt = {1'b1, r_tx_shift[8:1]};
            w_tx_cnt_nxt   = r_tx_cnt + 4'd1;
          end
        end
      end
      default: w_tx_state_nxt = TX_IDLE;
    endcase
  end

  assign TXD_o = r_txd;
  assign STB_o = r_stb;

  // ---------------- receiver ----------------
  logic       r_rx_meta, r_rx_sync, r_rx_prev;
  rx_state_t  r_rx_state, w_rx_state_nxt;
  logic [7:0] r_rx_shift, w_rx_shift_nxt;
  logic [2:0] r_rx_cnt,   w_rx_cnt_nxt;
  logic [7:0] r_rx_byte;
  logic       r_done;
  logic       w_rx_tick, w_rx_tmr_start, w_rx_tmr_stop, w_rx_load;

  uart_bit_timer #(.C_DIV(LP_DIV)) u_rx_timer (
    .i_ck   (CK_i),
    .i_rst  (RST_i),
    .i_start(w_rx_tmr_start),
    .i_half (1'b1),
    .i_stop (w_rx_tmr_stop),
    .o_tick (w_rx_tick)
  );

  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_shift <= '0;
      r_rx_cnt   <= '0;
      r_rx_byte  <= '0;
      r_done     <= 1'b0;
    end else begin
      r_rx_meta  <= RXD_i;
      r_rx_sync  <= r_rx_meta;
      r_rx_prev  <= r_rx_sync;
      r_rx_state <= w_rx_state_nxt;
      r_rx_shift <= w_rx_shift_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_done     <= w_rx_load;
      if (w_rx_load) r_rx_byte <= r_rx_shift;
    end
  end

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_shift_nxt = r_rx_shift;
    w_rx_cnt_nxt   = r_rx_cnt;
    w_rx_tmr_start = 1'b0;
    w_rx_tmr_stop  = 1'b0;
    w_rx_load      = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        if (r_rx_prev && !r_rx_sync) begin
          w_rx_tmr_start = 1'b1;
          w_rx_state_nxt = RX_START;
        end
      end
      RX_START: begin
        if (w_rx_tick) begin
          if (r_rx_sync) begin
            w_rx_tmr_stop  = 1'b1;
            w_rx_state_nxt = RX_IDLE;
          end else begin
            w_rx_cnt_nxt   = '0;
            w_rx_state_nxt = RX_DATA;
          end
        end
      end
      RX_DATA: begin
        if (w_rx_tick) begin
          w_rx_shift_nxt = {r_rx_sync, r_rx_shift[7:1]};
          w_rx_cnt_nxt   = r_rx_cnt + 3'd1;
          if (r_rx_cnt == 3'd7) w_rx_state_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (w_rx_tick) begin
          w_rx_tmr_stop = 1'b1;
          if (r_rx_sync) begin
            w_rx_load      = 1'b1;
            w_rx_state_nxt = RX_IDLE;
          end else begin
            w_rx_state_nxt = RX_WAIT_HIGH;
          end
        end
      end
      RX_WAIT_HIGH: begin
        // A framing error leaves the line low; re-arm only once it is released.
        if (r_rx_sync) w_rx_state_nxt = RX_IDLE;
      end
      default: w_rx_state_nxt = RX_IDLE;
    endcase
  end

  assign BYTEs_o = r_rx_byte;
  assign DONE_o  = r_done;

`ifdef UART_RX_CMD_DECODE_EN
  rx_flags_t r_rx_flags;

  always_ff @(posedge CK_i) begin
    if (RST_i)          r_rx_flags <= '0;
    else if (w_rx_load) r_rx_flags <= decode_byte(r_rx_shift);
  end

  assign HEXs_o     = r_rx_flags.hex;
  assign CRLF_DET_o = r_rx_flags.crlf;
  assign W_DET_o    = r_rx_flags.w;
  assign R_DET_o    = r_rx_flags.r;
`else
  assign HEXs_o     = 4'h0;
  assign CRLF_DET_o = 1'b0;
  assign W_DET_o    = 1'b0;
  assign R_DET_o    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_txrx_core.sv
// Self-checking bench for uart_txrx_core at DIV=10: TX timing, decode, false start,
// framing error, full loopback, back-to-back and reset abort; scoreboard queue for RX.
module tb_uart_txrx_core;

  localparam int C_F_CK = 1000;
  localparam int C_BAUD = 100;
  localparam int DIV    = 10;
`ifdef UART_RX_CMD_DECODE_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  logic       ck = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_byte = 8'h00;
  logic       req = 1'b0;
  logic       rxd_drv = 1'b1;
  logic       loop_en = 1'b0;
  logic       rxd;
  logic       stb, txd, done, crlf, wdet, rdet;
  logic [7:0] rx_byte;
  logic [3:0] hex;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic [7:0] exp_q[$];

  assign rxd = loop_en ? txd : rxd_drv;

  uart_txrx_core #(.C_F_CK(C_F_CK), .C_BAUD(C_BAUD)) dut (
    .CK_i      (ck),
    .RST_i     (rst),
    .BYTEs_i   (tx_byte),
    .REQ_i     (req),
    .STB_o     (stb),
    .TXD_o     (txd),
    .RXD_i     (rxd),
    .BYTEs_o   (rx_byte),
    .DONE_o    (done),
    .HEXs_o    (hex),
    .CRLF_DET_o(crlf),
    .W_DET_o   (wdet),
    .R_DET_o   (rdet)
  );

  always #5 ck = ~ck;

  always @(negedge ck) if (done === 1'b1) done_cnt <= done_cnt + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  // Reference decode, written independently of the RTL.
  function automatic logic [3:0] model_hex(input logic [7:0] b);
    logic [3:0] v;
    v = 4'h0;
    if (DEC_EN) begin
      if (b >= "0" && b <= "9") v = b[3:0];
      else if ((b >= "A" && b <= "F") || (b >= "a" && b <= "f")) v = b[3:0] + 4'd9;
    end
    return v;
  endfunction

  function automatic logic [2:0] model_crw(input logic [7:0] b);
    return {DEC_EN && (b == 8'h0D || b == 8'h0A),
            DEC_EN && (b == 8'h57 || b == 8'h77),
            DEC_EN && (b == 8'h52 || b == 8'h72)};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge ck);
    #1;
  endtask

  task automatic send_serial(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd_drv = frame[i];
      tick(DIV);
    end
    rxd_drv = 1'b1;
  endtask

  task automatic wait_done(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge ck);
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; rxd_drv = 1'b1; loop_en = 1'b0;
    tick(3);
    @(negedge ck);
    total++; if (txd !== 1'b1) begin bad++; $display("FAIL reset_txd: got %b want 1", txd); end
    total++; if (stb !== 1'b1) begin bad++; $display("FAIL reset_stb: got %b want 1", stb); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (rx_byte !== 8'h00) begin bad++; $display("FAIL reset_byte: got %h want 00", rx_byte); end
    total++;
    if ({hex, crlf, wdet, rdet} !== 7'h00) begin
      bad++; $display("FAIL reset_flags: got %h want 00", {hex, crlf, wdet, rdet});
    end
    @(posedge ck); #1;
    rst = 1'b0;
    tick(5);
  endtask

  task automatic test_tx_timing();
    logic [9:0] frame;
    bit         bit_ok;
    logic       a_txd, a_stb;
    int         d0;
    frame = {1'b1, 8'h55, 1'b0};
    d0 = done_cnt;
    tx_byte = 8'h55; req = 1'b1;
    tick(1);
    req = 1'b0; tx_byte = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      bit_ok = 1'b1; a_txd = frame[i]; a_stb = 1'b0;
      for (int c = 0; c < DIV; c++) begin
        @(negedge ck);
        if (bit_ok && (txd !== frame[i] || stb !== 1'b0)) begin
          bit_ok = 1'b0; a_txd = txd; a_stb = stb;
        end
        if (i == 3 && c == 0) req = 1'b1;
        if (i == 4 && c == 0) req = 1'b0;
      end
      total++;
      if (!bit_ok) begin
        bad++; $display("FAIL tx_bit%0d: got txd=%b stb=%b want txd=%b stb=0", i, a_txd, a_stb, frame[i]);
      end
    end
    @(negedge ck);
    total++; if (stb !== 1'b1) begin bad++; $display("FAIL tx_stb_rise: got %b want 1 after 100 clocks", stb); end
    total++; if (txd !== 1'b1) begin bad++; $display("FAIL tx_idle_txd: got %b want 1", txd); end
    tick(20);
    total++; if (stb !== 1'b1) begin bad++; $display("FAIL tx_no_restart: stb=%b want 1", stb); end
    total++; if (done_cnt !== d0) begin bad++; $display("FAIL tx_rx_quiet: done count %0d want %0d", done_cnt, d0); end
  endtask

  typedef struct {
    logic [7:0] b;
    logic [3:0] hex;
    logic       crlf;
    logic       w;
    logic       r;
  } dec_vec_t;

  task automatic test_decode();
    dec_vec_t tbl[4];
    logic [7:0] e;
    bit got;
    tbl[0] = '{8'h61, DEC_EN ? 4'hA : 4'h0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{8'h57, 4'h0, 1'b0, DEC_EN, 1'b0};
    tbl[2] = '{8'h72, 4'h0, 1'b0, 1'b0, DEC_EN};
    tbl[3] = '{8'h0D, 4'h0, DEC_EN, 1'b0, 1'b0};
    loop_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(tbl[k].b);
      fork
        send_serial(tbl[k].b, 1'b1);
        begin
          wait_done(150, got);
          total++;
          if (!got) begin
            bad++; $display("FAIL decode_timeout%0d: no DONE_o, want byte %h", k, tbl[k].b);
          end else if (exp_q.size() == 0) begin
            bad++; $display("FAIL decode_sb%0d: DONE_o with empty scoreboard, byte %h", k, rx_byte);
          end else begin
            e = exp_q.pop_front();
            if (rx_byte !== e) begin bad++; $display("FAIL decode_byte%0d: got %h want %h", k, rx_byte, e); end
            total++;
            if ({hex, crlf, wdet, rdet} !== {tbl[k].hex, tbl[k].crlf, tbl[k].w, tbl[k].r}) begin
              bad++;
              $display("FAIL decode_flags%0d: got hex=%h crlf=%b w=%b r=%b want hex=%h crlf=%b w=%b r=%b",
                       k, hex, crlf, wdet, rdet, tbl[k].hex, tbl[k].crlf, tbl[k].w, tbl[k].r);
            end
          end
        end
      join
    end
    tick(20);
    total++;
    if (rx_byte !== 8'h0D || crlf !== DEC_EN) begin
      bad++; $display("FAIL decode_hold: got byte=%h crlf=%b want 0d/%b", rx_byte, crlf, DEC_EN);
    end
  endtask

  task automatic test_false_start();
    int d0;
    d0 = done_cnt;
    rxd_drv = 1'b0;
    tick(3);
    rxd_drv = 1'b1;
    tick(60);
    total++; if (done_cnt !== d0) begin bad++; $display("FAIL false_start: done count %0d want %0d", done_cnt, d0); end
  endtask

  task automatic test_framing();
    int d0;
    logic [7:0] prev, e;
    bit got;
    d0 = done_cnt; prev = rx_byte;
    send_serial(8'h96, 1'b0);
    tick(30);
    total++; if (done_cnt !== d0) begin bad++; $display("FAIL framing_done: done count %0d want %0d", done_cnt, d0); end
    total++; if (rx_byte !== prev) begin bad++; $display("FAIL framing_hold: got %h want %h", rx_byte, prev); end
    exp_q.push_back(8'h5A);
    fork
      send_serial(8'h5A, 1'b1);
      begin
        wait_done(150, got);
        total++;
        if (!got) begin
          bad++; $display("FAIL framing_recover_timeout: no DONE_o, want 5a");
        end else begin
          e = exp_q.pop_front();
          if (rx_byte !== e) begin bad++; $display("FAIL framing_recover: got %h want %h", rx_byte, e); end
        end
      end
    join
  endtask

  task automatic test_loopback();
    loop_en = 1'b1;
    tick(5);
    fork
      begin
        bit ok;
        for (int n = 0; n < 256; n++) begin
          tx_byte = 8'(n);
          exp_q.push_back(8'(n));
          req = 1'b1;
          ok = 1'b0;
          for (int c = 0; c < 300; c++) begin
            @(negedge ck);
            if (stb === 1'b0) begin ok = 1'b1; break; end
          end
          req = 1'b0;
          if (!ok) begin total++; bad++; $display("FAIL loop_stb_fall%0d: STB_o stayed %b, want 0", n, stb); break; end
          ok = 1'b0;
          for (int c = 0; c < 300; c++) begin
            @(negedge ck);
            if (stb === 1'b1) begin ok = 1'b1; break; end
          end
          if (!ok) begin total++; bad++; $display("FAIL loop_stb_rise%0d: STB_o stayed %b, want 1", n, stb); break; end
        end
      end
      begin
        bit got;
        logic [7:0] e;
        for (int n = 0; n < 256; n++) begin
          wait_done(400, got);
          total++;
          if (!got) begin bad++; $display("FAIL loop_timeout%0d: no DONE_o, want byte %h", n, n); break; end
          if (exp_q.size() == 0) begin bad++; $display("FAIL loop_sb%0d: DONE_o with empty scoreboard", n); break; end
          e = exp_q.pop_front();
          if (rx_byte !== e || hex !== model_hex(e) || {crlf, wdet, rdet} !== model_crw(e)) begin
            bad++;
            $display("FAIL loop_rx%0d: got byte=%h hex=%h crw=%b want byte=%h hex=%h crw=%b",
                     n, rx_byte, hex, {crlf, wdet, rdet}, e, model_hex(e), model_crw(e));
          end
        end
      end
    join
    tick(5);
  endtask

  task automatic test_back_to_back();
    int hi;
    loop_en = 1'b1;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'hC3);
    fork
      begin
        tx_byte = 8'hA5; req = 1'b1;
        for (int c = 0; c < 300; c++) begin @(negedge ck); if (stb === 1'b0) break; end
        tx_byte = 8'hC3;
        for (int c = 0; c < 300; c++) begin @(negedge ck); if (stb === 1'b1) break; end
        hi = (stb === 1'b1) ? 1 : 0;
        for (int c = 0; c < 50; c++) begin @(negedge ck); if (stb === 1'b1) hi++; else break; end
        req = 1'b0;
        total++; if (hi != 1) begin bad++; $display("FAIL b2b_gap: STB_o high %0d cycles want 1", hi); end
      end
      begin
        bit got;
        logic [7:0] e;
        for (int n = 0; n < 2; n++) begin
          wait_done(400, got);
          total++;
          if (!got) begin bad++; $display("FAIL b2b_timeout%0d: no DONE_o", n); break; end
          e = exp_q.pop_front();
          if (rx_byte !== e) begin bad++; $display("FAIL b2b_rx%0d: got %h want %h", n, rx_byte, e); end
        end
      end
    join
    tick(20);
  endtask

  task automatic test_reset_mid_tx();
    loop_en = 1'b0;
    tx_byte = 8'h00; req = 1'b1;
    tick(1);
    req = 1'b0;
    tick(25);
    total++; if (txd !== 1'b0) begin bad++; $display("FAIL rst_tx_pre: txd=%b want 0 mid-frame", txd); end
    rst = 1'b1;
    tick(1);
    @(negedge ck);
    total++; if (txd !== 1'b1) begin bad++; $display("FAIL rst_tx_txd: got %b want 1", txd); end
    total++; if (stb !== 1'b1) begin bad++; $display("FAIL rst_tx_stb: got %b want 1", stb); end
    @(posedge ck); #1;
    rst = 1'b0;
    tick(30);
    total++;
    if (txd !== 1'b1 || stb !== 1'b1) begin
      bad++; $display("FAIL rst_tx_after: txd=%b stb=%b want 1/1", txd, stb);
    end
  endtask

  task automatic test_reset_mid_rx();
    int d0;
    bit got;
    logic [7:0] e;
    d0 = done_cnt;
    fork
      send_serial(8'hFF, 1'b1);
      begin
        tick(40);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
      end
    join
    tick(150);
    total++; if (done_cnt !== d0) begin bad++; $display("FAIL rst_rx_done: done count %0d want %0d", done_cnt, d0); end
    total++; if (rx_byte !== 8'h00) begin bad++; $display("FAIL rst_rx_byte: got %h want 00", rx_byte); end
    exp_q.push_back(8'h42);
    fork
      send_serial(8'h42, 1'b1);
      begin
        wait_done(150, got);
        total++;
        if (!got) begin
          bad++; $display("FAIL rst_rx_recover_timeout: no DONE_o, want 42");
        end else begin
          e = exp_q.pop_front();
          if (rx_byte !== e) begin bad++; $display("FAIL rst_rx_recover: got %h want %h", rx_byte, e); end
        end
      end
    join
  endtask

  initial begin
    test_reset();
    test_tx_timing();
    test_decode();
    test_false_start();
    test_framing();
    test_loopback();
    test_back_to_back();
    test_reset_mid_tx();
    test_reset_mid_rx();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL sb_leftover: %0d bytes never received", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
